// File: rtl/branch_resolve.sv
// EX-stage branch resolution: evaluates each branch, produces the correct next PC,
// checks it against the fetch prediction and sends one resolution pulse to the PC unit.
module branch_resolve #(
    parameter int CNT_W   = 16,
    parameter bit FORE_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             br_valid_i,
    input  logic [2:0]       br_type_i,
    input  logic [31:0]      inst_addr_i,
    input  logic [31:0]      rs_data_i,
    input  logic [31:0]      rt_data_i,
    input  logic [15:0]      imm_i,
    input  logic [25:0]      jtarget_i,
    input  logic             pred_taken_i,
    input  logic [31:0]      pred_addr_i,
    input  logic             stall,
    input  logic             flush_i,
    input  logic             fore_cfg_i,
    output logic             valid_branch_o,
    output logic             suc_branch_o,
    output logic [31:0]      addr_branch_o,
    output logic [31:0]      inst_addr_o,
    output logic             ena_fore_o,
    output logic             br_busy_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    localparam logic [2:0] T_BEQ  = 3'd0;
    localparam logic [2:0] T_BNE  = 3'd1;
    localparam logic [2:0] T_BLEZ = 3'd2;
    localparam logic [2:0] T_BGTZ = 3'd3;
    localparam logic [2:0] T_BLTZ = 3'd4;
    localparam logic [2:0] T_BGEZ = 3'd5;
    localparam logic [2:0] T_J    = 3'd6;
    localparam logic [2:0] T_JR   = 3'd7;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              suc_q, suc_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       inst_q, inst_d;
    logic              hold_suc_q, hold_suc_d;
    logic [31:0]       hold_addr_q, hold_addr_d;
    logic [31:0]       hold_inst_q, hold_inst_d;
    logic [CNT_W-1:0]  br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
    logic              ena_q, ena_d;

    logic [31:0] seq_addr;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        taken;
    logic        calc_suc;

    assign seq_addr  = inst_addr_i + 32'd4;
    assign br_target = seq_addr + {{14{imm_i[15]}}, imm_i, 2'b00};
    assign j_target  = {seq_addr[31:28], jtarget_i, 2'b00};

    always_comb begin
        taken  = 1'b0;
        target = br_target;
        case (br_type_i)
            T_BEQ:   taken = (rs_data_i == rt_data_i);
            T_BNE:   taken = (rs_data_i != rt_data_i);
            T_BLEZ:  taken = ($signed(rs_data_i) <= 32'sd0);
            T_BGTZ:  taken = ($signed(rs_data_i) >  32'sd0);
            T_BLTZ:  taken = ($signed(rs_data_i) <  32'sd0);
            T_BGEZ:  taken = ($signed(rs_data_i) >= 32'sd0);
            T_J: begin
                taken  = 1'b1;
                target = j_target;
            end
            T_JR: begin
                taken  = 1'b1;
                target = rs_data_i;
            end
            default: taken = 1'b0;
        endcase
    end

    // A not-taken branch only needs the direction right; a taken one also needs the address.
    assign next_pc  = taken ? target : seq_addr;
    assign calc_suc = (pred_taken_i == taken) && (!taken || (pred_addr_i == next_pc));

    always_comb begin
        state_d     = state_q;
        valid_d     = 1'b0;
        suc_d       = suc_q;
        addr_d      = addr_q;
        inst_d      = inst_q;
        hold_suc_d  = hold_suc_q;
        hold_addr_d = hold_addr_q;
        hold_inst_d = hold_inst_q;
        case (state_q)
            IDLE: begin
                if (!flush_i && br_valid_i) begin
                    if (stall) begin
                        hold_suc_d  = calc_suc;
                        hold_addr_d = next_pc;
                        hold_inst_d = inst_addr_i;
                        state_d     = PEND;
                    end else begin
                        valid_d = 1'b1;
                        suc_d   = calc_suc;
                        addr_d  = next_pc;
                        inst_d  = inst_addr_i;
                    end
                end
            end
            PEND: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (!stall) begin
                    valid_d = 1'b1;
                    suc_d   = hold_suc_q;
                    addr_d  = hold_addr_q;
                    inst_d  = hold_inst_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        br_cnt_d   = valid_d ? br_cnt_q + CNT_W'(1) : br_cnt_q;
        miss_cnt_d = (valid_d && !suc_d) ? miss_cnt_q + CNT_W'(1) : miss_cnt_q;
        // Predictor enable only moves when no resolution is in flight or being reported.
        ena_d      = (state_q == IDLE && !valid_q) ? fore_cfg_i : ena_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            suc_q       <= 1'b0;
            addr_q      <= '0;
            inst_q      <= '0;
            hold_suc_q  <= 1'b0;
            hold_addr_q <= '0;
            hold_inst_q <= '0;
            br_cnt_q    <= '0;
            miss_cnt_q  <= '0;
            ena_q       <= FORE_EN;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            suc_q       <= suc_d;
            addr_q      <= addr_d;
            inst_q      <= inst_d;
            hold_suc_q  <= hold_suc_d;
            hold_addr_q <= hold_addr_d;
            hold_inst_q <= hold_inst_d;
            br_cnt_q    <= br_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            ena_q       <= ena_d;
        end
    end

    assign valid_branch_o = valid_q;
    assign suc_branch_o   = suc_q;
    assign addr_branch_o  = addr_q;
    assign inst_addr_o    = inst_q;
    assign ena_fore_o     = ena_q;
    assign br_busy_o      = (state_q == PEND);
    assign br_cnt_o       = br_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed vector table, hand-written stall/flush/reset
// sequences and a randomized run, all against a queue-based reference model.
module tb_branch_resolve;

    logic        clk;
    logic        rst;
    logic        brValid;
    logic [2:0]  brType;
    logic [31:0] instAddr;
    logic [31:0] rsData;
    logic [31:0] rtData;
    logic [15:0] imm;
    logic [25:0] jtarget;
    logic        predTaken;
    logic [31:0] predAddr;
    logic        stall;
    logic        flush;
    logic        foreCfg;

    logic        validBranch;
    logic        sucBranch;
    logic [31:0] addrBranch;
    logic [31:0] instAddrOut;
    logic        enaFore;
    logic        brBusy;
    logic [15:0] brCnt;
    logic [15:0] missCnt;

    logic        smValid;
    logic        smSuc;
    logic [31:0] smAddr;
    logic [31:0] smInst;
    logic        smEna;
    logic        smBusy;
    logic [3:0]  smBrCnt;
    logic [3:0]  smMissCnt;

    int testsRun;
    int testsFailed;

    branch_resolve dut (
        .clk(clk), .rst(rst), .br_valid_i(brValid), .br_type_i(brType),
        .inst_addr_i(instAddr), .rs_data_i(rsData), .rt_data_i(rtData), .imm_i(imm),
        .jtarget_i(jtarget), .pred_taken_i(predTaken), .pred_addr_i(predAddr),
        .stall(stall), .flush_i(flush), .fore_cfg_i(foreCfg),
        .valid_branch_o(validBranch), .suc_branch_o(sucBranch), .addr_branch_o(addrBranch),
        .inst_addr_o(instAddrOut), .ena_fore_o(enaFore), .br_busy_o(brBusy),
        .br_cnt_o(brCnt), .miss_cnt_o(missCnt)
    );

    branch_resolve #(.CNT_W(4)) dutSmall (
        .clk(clk), .rst(rst), .br_valid_i(brValid), .br_type_i(brType),
        .inst_addr_i(instAddr), .rs_data_i(rsData), .rt_data_i(rtData), .imm_i(imm),
        .jtarget_i(jtarget), .pred_taken_i(predTaken), .pred_addr_i(predAddr),
        .stall(stall), .flush_i(flush), .fore_cfg_i(foreCfg),
        .valid_branch_o(smValid), .suc_branch_o(smSuc), .addr_branch_o(smAddr),
        .inst_addr_o(smInst), .ena_fore_o(smEna), .br_busy_o(smBusy),
        .br_cnt_o(smBrCnt), .miss_cnt_o(smMissCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        suc;
        logic [31:0] addr;
        logic [31:0] inst;
    } res_t;

    typedef struct {
        logic [2:0]  bt;
        logic [31:0] pc;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] im;
        logic [25:0] jt;
        logic        pt;
        logic [31:0] pa;
        logic        expSuc;
        logic [31:0] expAddr;
    } vec_t;

    // Reference model state: outstanding branches plus the expected visible outputs.
    res_t        pendQ[$];
    logic        expValid;
    logic        expSuc;
    logic [31:0] expAddr;
    logic [31:0] expInst;
    logic        expEna;
    logic        expBusy;
    logic [15:0] expBr;
    logic [15:0] expMiss;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refResolve(input logic [2:0] bt, input logic [31:0] pc, input logic [31:0] rs,
                              input logic [31:0] rt, input logic [15:0] im, input logic [25:0] jt,
                              input logic pt, input logic [31:0] pa,
                              output logic suc, output logic [31:0] nxt);
        logic [31:0] seqPc;
        logic [31:0] tgt;
        logic        tk;
        int          rsInt;
        seqPc = pc + 32'd4;
        tgt   = seqPc + 32'(int'($signed(im)) * 4);
        rsInt = int'($signed(rs));
        case (bt)
            3'd0: tk = (rs == rt);
            3'd1: tk = (rs != rt);
            3'd2: tk = (rsInt <= 0);
            3'd3: tk = (rsInt > 0);
            3'd4: tk = (rsInt < 0);
            3'd5: tk = (rsInt >= 0);
            3'd6: begin
                tk  = 1'b1;
                tgt = (seqPc & 32'hF000_0000) + (32'(jt) * 4);
            end
            default: begin
                tk  = 1'b1;
                tgt = rs;
            end
        endcase
        nxt = tk ? tgt : seqPc;
        suc = (pt == tk) && (!tk || pa == nxt);
    endtask

    task automatic emit(input res_t r);
        expValid = 1'b1;
        expSuc   = r.suc;
        expAddr  = r.addr;
        expInst  = r.inst;
        expBr    = expBr + 16'd1;
        if (!r.suc) expMiss = expMiss + 16'd1;
    endtask

    task automatic modelStep();
        logic pulseNow;
        logic idleNow;
        res_t r;
        pulseNow = expValid;
        idleNow  = (pendQ.size() == 0);
        expValid = 1'b0;
        if (!rst) begin
            pendQ.delete();
            expSuc  = 1'b0;
            expAddr = '0;
            expInst = '0;
            expBr   = '0;
            expMiss = '0;
            expEna  = 1'b1;
        end else begin
            if (flush) begin
                pendQ.delete();
            end else if (pendQ.size() != 0) begin
                if (!stall) begin
                    r = pendQ.pop_front();
                    emit(r);
                end
            end else if (brValid) begin
                refResolve(brType, instAddr, rsData, rtData, imm, jtarget, predTaken, predAddr,
                           r.suc, r.addr);
                r.inst = instAddr;
                if (stall) pendQ.push_back(r);
                else emit(r);
            end
            if (!pulseNow && idleNow) expEna = foreCfg;
        end
        expBusy = (pendQ.size() != 0);
    endtask

    task automatic checkOutput();
        check("valid", 32'(validBranch), 32'(expValid));
        check("suc", 32'(sucBranch), 32'(expSuc));
        check("addr", addrBranch, expAddr);
        check("inst", instAddrOut, expInst);
        check("ena", 32'(enaFore), 32'(expEna));
        check("busy", 32'(brBusy), 32'(expBusy));
        check("brCnt", 32'(brCnt), 32'(expBr));
        check("missCnt", 32'(missCnt), 32'(expMiss));
        check("smBrCnt", 32'(smBrCnt), 32'(expBr[3:0]));
        check("smMissCnt", 32'(smMissCnt), 32'(expMiss[3:0]));
    endtask

    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic setBranch(input logic [2:0] bt, input logic [31:0] pc, input logic [31:0] rs,
                             input logic [31:0] rt, input logic [15:0] im, input logic [25:0] jt,
                             input logic pt, input logic [31:0] pa);
        brValid   = 1'b1;
        brType    = bt;
        instAddr  = pc;
        rsData    = rs;
        rtData    = rt;
        imm       = im;
        jtarget   = jt;
        predTaken = pt;
        predAddr  = pa;
    endtask

    task automatic doReset();
        rst     = 1'b0;
        brValid = 1'b0;
        stall   = 1'b0;
        flush   = 1'b0;
        foreCfg = 1'b1;
        applyStimulus();
        applyStimulus();
        rst = 1'b1;
    endtask

    vec_t        vecs[10];
    logic [15:0] savedBr;
    logic [15:0] savedMiss;
    logic        rSuc;
    logic [31:0] rNext;

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        expValid    = 1'b0;
        expSuc      = 1'b0;
        expAddr     = '0;
        expInst     = '0;
        expEna      = 1'b1;
        expBusy     = 1'b0;
        expBr       = '0;
        expMiss     = '0;
        brType      = '0;
        instAddr    = '0;
        rsData      = '0;
        rtData      = '0;
        imm         = '0;
        jtarget     = '0;
        predTaken   = 1'b0;
        predAddr    = '0;

        vecs[0] = '{3'd0, 32'h100, 32'd5, 32'd5, 16'h0004, 26'd0, 1'b1, 32'h114, 1'b1, 32'h114};
        vecs[1] = '{3'd1, 32'h200, 32'd7, 32'd7, 16'h0010, 26'd0, 1'b1, 32'h180, 1'b0, 32'h204};
        vecs[2] = '{3'd5, 32'h300, 32'hFFFF_FFFF, 32'd0, 16'hFFFF, 26'd0, 1'b0, 32'h0, 1'b1, 32'h304};
        vecs[3] = '{3'd5, 32'h300, 32'd0, 32'd0, 16'hFFFF, 26'd0, 1'b0, 32'h0, 1'b0, 32'h300};
        vecs[4] = '{3'd2, 32'h1000, 32'd0, 32'd9, 16'h0008, 26'd0, 1'b1, 32'h1024, 1'b1, 32'h1024};
        vecs[5] = '{3'd3, 32'h2000, 32'd0, 32'd0, 16'h0008, 26'd0, 1'b0, 32'h0, 1'b1, 32'h2004};
        vecs[6] = '{3'd4, 32'h3000, 32'h8000_0000, 32'd0, 16'hFFF0, 26'd0, 1'b1, 32'h2FC0, 1'b0, 32'h2FC4};
        vecs[7] = '{3'd6, 32'hA000_0010, 32'd0, 32'd0, 16'h0, 26'h0123456, 1'b1, 32'hA048_D158, 1'b1, 32'hA048_D158};
        vecs[8] = '{3'd7, 32'h40, 32'h8000_0000, 32'd0, 16'h0, 26'd0, 1'b1, 32'h8000_0000, 1'b1, 32'h8000_0000};
        vecs[9] = '{3'd0, 32'h500, 32'd1, 32'd1, 16'h0002, 26'd0, 1'b1, 32'h510, 1'b0, 32'h50C};

        doReset();
        check("resetEna", 32'(enaFore), 32'd1);
        check("resetBrCnt", 32'(brCnt), 32'd0);

        // Directed table, one branch per cycle with no stall.
        for (int i = 0; i < 10; i++) begin
            setBranch(vecs[i].bt, vecs[i].pc, vecs[i].rs, vecs[i].rt, vecs[i].im, vecs[i].jt,
                      vecs[i].pt, vecs[i].pa);
            applyStimulus();
            check($sformatf("vec%0d_valid", i), 32'(validBranch), 32'd1);
            check($sformatf("vec%0d_suc", i), 32'(sucBranch), 32'(vecs[i].expSuc));
            check($sformatf("vec%0d_addr", i), addrBranch, vecs[i].expAddr);
            check($sformatf("vec%0d_inst", i), instAddrOut, vecs[i].pc);
        end
        brValid = 1'b0;
        applyStimulus();
        check("tableBrCnt", 32'(brCnt), 32'd10);
        check("tableMissCnt", 32'(missCnt), 32'd4);

        // JR held in PEND by a 3-cycle stall.
        setBranch(3'd7, 32'h40, 32'h8000_0000, 32'd0, 16'h0, 26'd0, 1'b1, 32'h8000_0000);
        stall = 1'b1;
        applyStimulus();
        brValid = 1'b0;
        check("jrBusy0", 32'(brBusy), 32'd1);
        applyStimulus();
        check("jrBusy1", 32'(brBusy), 32'd1);
        applyStimulus();
        check("jrBusy2", 32'(brBusy), 32'd1);
        check("jrNoPulse", 32'(validBranch), 32'd0);
        stall = 1'b0;
        applyStimulus();
        check("jrPulse", 32'(validBranch), 32'd1);
        check("jrAddr", addrBranch, 32'h8000_0000);
        applyStimulus();
        check("jrPulseEnds", 32'(validBranch), 32'd0);

        // Flush of a captured branch, then flush racing a new branch.
        savedBr   = brCnt;
        savedMiss = missCnt;
        setBranch(3'd0, 32'h600, 32'd3, 32'd3, 16'h0001, 26'd0, 1'b0, 32'h0);
        stall = 1'b1;
        applyStimulus();
        brValid = 1'b0;
        flush   = 1'b1;
        applyStimulus();
        check("flushBusy", 32'(brBusy), 32'd0);
        flush = 1'b0;
        stall = 1'b0;
        applyStimulus();
        check("flushNoPulse", 32'(validBranch), 32'd0);
        setBranch(3'd6, 32'h700, 32'd0, 32'd0, 16'h0, 26'h10, 1'b1, 32'h40);
        flush = 1'b1;
        applyStimulus();
        check("flushRaceNoPulse", 32'(validBranch), 32'd0);
        check("flushBrCnt", 32'(brCnt), 32'(savedBr));
        check("flushMissCnt", 32'(missCnt), 32'(savedMiss));
        brValid = 1'b0;
        flush   = 1'b0;

        // Predictor enable frozen across a pending resolution.
        foreCfg = 1'b0;
        applyStimulus();
        check("enaOff", 32'(enaFore), 32'd0);
        setBranch(3'd1, 32'h800, 32'd1, 32'd2, 16'h0004, 26'd0, 1'b1, 32'h814);
        stall = 1'b1;
        applyStimulus();
        brValid = 1'b0;
        foreCfg = 1'b1;
        applyStimulus();
        check("enaFrozenPend", 32'(enaFore), 32'd0);
        stall = 1'b0;
        applyStimulus();
        check("enaFrozenPulseEdge", 32'(enaFore), 32'd0);
        applyStimulus();
        check("enaFrozenPulse", 32'(enaFore), 32'd0);
        applyStimulus();
        check("enaOn", 32'(enaFore), 32'd1);

        // Reset while a branch is pending.
        setBranch(3'd7, 32'h900, 32'h1234, 32'd0, 16'h0, 26'd0, 1'b0, 32'h0);
        stall = 1'b1;
        foreCfg = 1'b0;
        applyStimulus();
        brValid = 1'b0;
        rst = 1'b0;
        applyStimulus();
        check("rstPendBusy", 32'(brBusy), 32'd0);
        check("rstPendAddr", addrBranch, 32'd0);
        check("rstPendEna", 32'(enaFore), 32'd1);
        rst   = 1'b1;
        stall = 1'b0;
        applyStimulus();
        check("rstPendNoPulse", 32'(validBranch), 32'd0);

        // Counter wrap on the 4-bit instance: 17 branches.
        doReset();
        for (int i = 0; i < 17; i++) begin
            setBranch(3'd0, 32'h1000 + 32'(i * 4), 32'd1, 32'd2, 16'h0003, 26'd0, 1'b0, 32'h0);
            applyStimulus();
        end
        brValid = 1'b0;
        applyStimulus();
        check("wrapSmallBrCnt", 32'(smBrCnt), 32'd1);
        check("wrapBrCnt", 32'(brCnt), 32'd17);

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 600; i++) begin
            brValid  = ($urandom_range(0, 99) < 55);
            brType   = 3'($urandom_range(0, 7));
            instAddr = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
            case ($urandom_range(0, 3))
                0: rsData = 32'd0;
                1: rsData = 32'h8000_0000 | $urandom();
                default: rsData = $urandom();
            endcase
            rtData   = ($urandom_range(0, 1) == 1) ? rsData : $urandom();
            imm      = 16'($urandom());
            jtarget  = 26'($urandom());
            predTaken = 1'($urandom_range(0, 1));
            refResolve(brType, instAddr, rsData, rtData, imm, jtarget, 1'b1, 32'h0, rSuc, rNext);
            case ($urandom_range(0, 2))
                0: predAddr = rNext;
                1: predAddr = instAddr + 32'd4;
                default: predAddr = $urandom();
            endcase
            stall   = ($urandom_range(0, 99) < 30);
            flush   = ($urandom_range(0, 99) < 7);
            rst     = ($urandom_range(0, 99) >= 2);
            if ($urandom_range(0, 9) == 0) foreCfg = ~foreCfg;
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
